// File: rtl/main_mem_lat_pkg.sv
// mem_pkg: shared FSM state type, lane width and mask expansion for main_mem_lat
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int WORD_W    = 32;
    localparam int MAX_W     = 1024;
    localparam int MAX_WORDS = MAX_W / WORD_W;

    // Turns a per-lane mask into a per-bit mask; lanes at or above 'words' stay zero
    function automatic logic [MAX_W-1:0] expand_mask(input logic [MAX_WORDS-1:0] m, input int words);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WORDS; i++)
            if (i < words)
                r[i*WORD_W +: WORD_W] = {WORD_W{m[i]}};
        return r;
    endfunction

endpackage

// File: rtl/main_mem_lat_ctr.sv
// mem_lat_ctr: loadable down-counter that saturates at zero and flags it
//   clk, rst_n : clock, asynchronous active-low reset (count returns to 0)
//   i_load     : load i_val (has priority over decrement)
//   i_val      : value to load
//   i_dec      : decrement by one while nonzero
//   o_zero     : count is zero
module mem_lat_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/main_mem_lat.sv
// main_mem_lat: single-outstanding line memory with separate read/write latencies and word masks
//   clk, rst_n          : clock, asynchronous active-low reset (storage is not cleared)
//   req_valid/req_ready : request handshake; ready only in IDLE
//   req_we              : 1 = write, 0 = read
//   req_addr            : line address
//   req_wdata/req_wmask : write data and per-32-bit-lane enable
//   rsp_valid/rsp_ready : response handshake
//   rsp_we              : echo of the request direction
//   rsp_rdata           : read data, zero for write acknowledges
//   busy                : not in IDLE
module main_mem_lat
    import mem_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 5,
    parameter int WR_LAT = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/WORD_W-1:0]   req_wmask,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_we,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       busy
);

    localparam int WORDS   = DATA_W / WORD_W;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    if (RD_LAT < 1 || WR_LAT < 1 || DATA_W % WORD_W != 0 || DATA_W > MAX_W) begin : g_bad_params
        $error("main_mem_lat: illegal parameters");
    end

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_bmask;
    logic              r_rsp_valid;
    logic              r_rsp_we;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    logic              w_accept;
    logic              w_zero;
    logic              w_done;
    logic [CW-1:0]     w_load_val;

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_done     = (r_state == WAIT) && w_zero;
    assign w_load_val = req_we ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_we     = r_rsp_we;
    assign rsp_rdata  = r_rdata;

    mem_lat_ctr #(.W(CW)) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_val  (w_load_val),
        .i_dec  (r_state == WAIT),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_bmask     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_state <= WAIT;
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_bmask <= DATA_W'(expand_mask(MAX_WORDS'(req_wmask), WORDS));
                end
                // Read data is sampled on the same edge a write would commit
                WAIT: if (w_zero) begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_we    <= r_we;
                    r_rdata     <= r_we ? '0 : r_mem[r_addr];
                end
                RESP: if (rsp_ready) begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_we    <= 1'b0;
                    r_rdata     <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Storage has no reset; a write only lands when WAIT completes, so reset before then drops it
    always_ff @(posedge clk) begin
        if (w_done && r_we)
            r_mem[r_addr] <= (r_mem[r_addr] & ~r_bmask) | (r_wdata & r_bmask);
    end

endmodule

// File: tb/tb_main_mem_lat.sv
// tb_main_mem_lat: scoreboard bench for main_mem_lat with two latency configurations
module tb_main_mem_lat;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid [2];
    logic         req_ready [2];
    logic         req_we    [2];
    logic [9:0]   req_addr  [2];
    logic [127:0] req_wdata [2];
    logic [3:0]   req_wmask [2];
    logic         rsp_valid [2];
    logic         rsp_ready [2];
    logic         rsp_we    [2];
    logic [127:0] rsp_rdata [2];
    logic         busy      [2];

    main_mem_lat #(.DATA_W(128), .ADDR_W(10), .RD_LAT(5), .WR_LAT(5)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we[0]),
        .rsp_rdata(rsp_rdata[0]), .busy(busy[0])
    );

    main_mem_lat #(.DATA_W(128), .ADDR_W(10), .RD_LAT(1), .WR_LAT(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we[1]),
        .rsp_rdata(rsp_rdata[1]), .busy(busy[1])
    );

    typedef struct {
        bit           we;
        logic [127:0] rd;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         q [2][$];
    logic [127:0] mdl [2][16];
    int           rdl [2] = '{5, 1};
    int           wrl [2] = '{5, 8};
    int           mode [2] = '{0, 0};
    int           hold [2] = '{0, 0};
    bit           seen [2] = '{0, 0};
    bit           post_hs [2] = '{0, 0};
    logic [127:0] first_d [2];
    logic         first_we [2];
    int           cyc = 0;
    int           checks = 0;
    int           passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: always ready; mode 1: random; mode 2: hold low for 4 cycles of each response
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            if (mode[k] == 0) rsp_ready[k] = 1'b1;
            else if (mode[k] == 1) rsp_ready[k] = 1'($urandom % 2);
            else if (!rsp_valid[k]) begin
                hold[k] = 0;
                rsp_ready[k] = 1'b0;
            end else if (hold[k] < 4) begin
                hold[k]++;
                rsp_ready[k] = 1'b0;
            end else rsp_ready[k] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                seen[k] = 0;
                post_hs[k] = 0;
            end else begin
                if (post_hs[k]) begin
                    chk("idle_after_hs_valid", rsp_valid[k], 0);
                    chk("idle_after_hs_ready", req_ready[k], 1);
                    post_hs[k] = 0;
                end
                if (rsp_valid[k]) begin
                    if (!seen[k]) begin
                        seen[k] = 1;
                        first_d[k] = rsp_rdata[k];
                        first_we[k] = rsp_we[k];
                        if (q[k].size() == 0) chk("unexpected_rsp", 1, 0);
                        else chk("latency", cyc - q[k][0].acc, q[k][0].lat);
                    end else begin
                        chk("hold_rdata", rsp_rdata[k], first_d[k]);
                        chk("hold_we", rsp_we[k], first_we[k]);
                    end
                    chk("req_ready_in_resp", req_ready[k], 0);
                    if (rsp_ready[k]) begin
                        if (q[k].size() != 0) begin
                            chk("rsp_we", rsp_we[k], q[k][0].we);
                            chk("rsp_rdata", rsp_rdata[k], q[k][0].rd);
                            void'(q[k].pop_front());
                        end
                        seen[k] = 0;
                        post_hs[k] = 1;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where the DUT is idle again
    task automatic issue(input int k, input bit we, input logic [3:0] a, input logic [127:0] d,
                         input logic [3:0] m, output int acc);
        exp_t e;
        int n;
        n = 0;
        acc = 0;
        while (!req_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = {6'd0, a};
        req_wdata[k] = d;
        req_wmask[k] = m;
        acc = cyc + 1;
        e.we  = we;
        e.rd  = we ? '0 : mdl[k][a];
        e.lat = we ? wrl[k] : rdl[k];
        e.acc = acc;
        if (we)
            for (int i = 0; i < 4; i++)
                if (m[i]) mdl[k][a][32*i +: 32] = d[32*i +: 32];
        q[k].push_back(e);
        @(negedge clk);
        n = 0;
        while (busy[k] && n < 300) begin
            req_valid[k] = 1'($urandom % 2);
            req_we[k]    = 1'($urandom % 2);
            req_addr[k]  = 10'($urandom);
            req_wdata[k] = rnd128();
            req_wmask[k] = 4'($urandom);
            @(negedge clk);
            n++;
        end
        req_valid[k] = 1'b0;
        if (busy[k]) chk("busy_timeout", 1, 0);
    endtask

    initial begin
        int a1, a2, a3, a4, acc;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_we[k] = 0; req_addr[k] = '0;
            req_wdata[k] = '0; req_wmask[k] = '0; rsp_ready[k] = 0;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", req_ready[k], 1);
            chk("rst_rsp_valid", rsp_valid[k], 0);
            chk("rst_rsp_we", rsp_we[k], 0);
            chk("rst_rsp_rdata", rsp_rdata[k], 0);
            chk("rst_busy", busy[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++)
                issue(k, 1, 4'(a), rnd128(), 4'hf, acc);
        issue(0, 1, 4'h5, 128'h11112222_33334444_55556666_77778888, 4'b1111, acc);
        issue(0, 0, 4'h5, '0, 4'h0, acc);
        issue(0, 1, 4'h5, {4{32'hFFFFFFFF}}, 4'b0101, acc);
        issue(0, 0, 4'h5, '0, 4'h0, acc);
        issue(0, 1, 4'h5, rnd128(), 4'b0000, acc);
        issue(0, 0, 4'h5, '0, 4'h0, acc);
        mode[0] = 2;
        issue(0, 0, 4'h5, '0, 4'h0, acc);
        issue(0, 1, 4'h3, rnd128(), 4'b1010, acc);
        mode[0] = 0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 10'h00A;
        req_wdata[0] = {4{32'hDEADBEEF}};
        req_wmask[0] = 4'hf;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("wait_rst_rsp_valid", rsp_valid[0], 0);
        chk("wait_rst_req_ready", req_ready[0], 1);
        chk("wait_rst_busy", busy[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_rsp_after_rst", rsp_valid[0], 0);
        issue(0, 0, 4'hA, '0, 4'h0, acc);
        mode[0] = 1;
        for (int i = 0; i < 60; i++)
            issue(0, 1'($urandom % 2), 4'($urandom), rnd128(), 4'($urandom), acc);
        issue(1, 0, 4'h3, '0, 4'h0, a1);
        issue(1, 0, 4'h4, '0, 4'h0, a2);
        issue(1, 1, 4'h4, rnd128(), 4'b0110, a3);
        issue(1, 0, 4'h4, '0, 4'h0, a4);
        chk("b2b_read_read", a2 - a1, 3);
        chk("b2b_read_write", a3 - a2, 3);
        chk("b2b_write_read", a4 - a3, 10);
        mode[1] = 1;
        for (int i = 0; i < 30; i++)
            issue(1, 1'($urandom % 2), 4'($urandom), rnd128(), 4'($urandom), acc);
        repeat (4) @(negedge clk);
        chk("queues_drained", q[0].size() + q[1].size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
